// File: rtl/sy_dma_desc_queue.sv
// Descriptor FIFO plus splitter: turns (src, dst, len) copy descriptors into aligned bursts
// and raises irq_o once every burst of a descriptor has completed. Option: SY_DMA_DESC_4K_SPLIT_EN.
module sy_dma_desc_queue #(
    parameter int ADDR_W    = 64,
    parameter int LEN_W     = 32,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 256,
    parameter int MAX_OUT   = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         desc_valid_i,
    output logic                         desc_ready_o,
    input  logic [ADDR_W-1:0]            desc_src_i,
    input  logic [ADDR_W-1:0]            desc_dst_i,
    input  logic [LEN_W-1:0]             desc_len_i,
    output logic                         req_valid_o,
    input  logic                         req_ready_i,
    output logic [ADDR_W-1:0]            req_src_o,
    output logic [ADDR_W-1:0]            req_dst_o,
    output logic [$clog2(MAX_BURST):0]   req_len_o,
    input  logic                         cpl_i,
    output logic                         irq_o,
    output logic                         err_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH):0]       desc_cnt_o,
    output logic [1:0]                   dbg_state_o
);
    localparam int OFF_W = $clog2(MAX_BURST);
    localparam int BL_W  = OFF_W + 1;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = PW + 1;
    localparam int OC_W  = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_e;

    // Handshakes (all ports): a transfer happens on a rising clk_i edge where valid && ready;
    // the producer holds its payload stable while valid && !ready.

`ifdef SY_DMA_DESC_4K_SPLIT_EN
    function automatic logic [BL_W-1:0] burst_len(input logic [OFF_W-1:0] src_off,
                                                  input logic [11:0] dst_off,
                                                  input logic [LEN_W-1:0] rem_v);
        logic [LEN_W-1:0] lim;
        logic [LEN_W-1:0] page_lim;
        lim      = LEN_W'(MAX_BURST) - LEN_W'(src_off);
        page_lim = LEN_W'(4096) - LEN_W'(dst_off);
        if (page_lim < lim) lim = page_lim;
        if (rem_v < lim) lim = rem_v;
        return BL_W'(lim);
    endfunction
`else
    function automatic logic [BL_W-1:0] burst_len(input logic [OFF_W-1:0] src_off,
                                                  input logic [LEN_W-1:0] rem_v);
        logic [LEN_W-1:0] lim;
        lim = LEN_W'(MAX_BURST) - LEN_W'(src_off);
        if (rem_v < lim) lim = rem_v;
        return BL_W'(lim);
    endfunction
`endif

    logic [ADDR_W-1:0] fifo_src_q [DEPTH];
    logic [ADDR_W-1:0] fifo_dst_q [DEPTH];
    logic [LEN_W-1:0]  fifo_len_q [DEPTH];

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OC_W-1:0]   out_cnt_q, out_cnt_d;
    logic [ADDR_W-1:0] cur_src_q, cur_src_d, cur_dst_q, cur_dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              req_valid_q, req_valid_d;
    logic [BL_W-1:0]   req_len_q, req_len_d;
    logic              irq_q, irq_d, err_q, err_d, busy_q, busy_d;

    logic push, store, pop, hs, cpl_ok;

    assign pop          = (state_q == IDLE) && (cnt_q != '0);
    // A pop frees a slot in the same cycle, so a full FIFO can still take a push then.
    assign desc_ready_o = (cnt_q != CW'(DEPTH)) || pop;
    assign push         = desc_valid_i && desc_ready_o;
    assign store        = push && (desc_len_i != '0);
    assign hs           = req_valid_q && req_ready_i;
    assign cpl_ok       = cpl_i && (out_cnt_q != '0);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(store) - CW'(pop);
        wr_ptr_d  = wr_ptr_q + PW'(store);
        rd_ptr_d  = rd_ptr_q + PW'(pop);
        out_cnt_d = out_cnt_q + OC_W'(hs) - OC_W'(cpl_ok);
        cur_src_d = cur_src_q;
        cur_dst_d = cur_dst_q;
        rem_d     = rem_q;
        irq_d     = 1'b0;
        err_d     = (push && (desc_len_i == '0)) || (cpl_i && (out_cnt_q == '0));
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d   = ISSUE;
                    cur_src_d = fifo_src_q[rd_ptr_q];
                    cur_dst_d = fifo_dst_q[rd_ptr_q];
                    rem_d     = fifo_len_q[rd_ptr_q];
                end
            end
            ISSUE: begin
                if (hs) begin
                    cur_src_d = cur_src_q + ADDR_W'(req_len_q);
                    cur_dst_d = cur_dst_q + ADDR_W'(req_len_q);
                    rem_d     = rem_q - LEN_W'(req_len_q);
                    if (rem_d == '0) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (out_cnt_d == '0) begin
                    state_d = IDLE;
                    irq_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Request registers always describe the burst starting at the next working position.
        req_valid_d = (state_d == ISSUE) && (out_cnt_d < OC_W'(MAX_OUT));
`ifdef SY_DMA_DESC_4K_SPLIT_EN
        req_len_d   = burst_len(cur_src_d[OFF_W-1:0], cur_dst_d[11:0], rem_d);
`else
        req_len_d   = burst_len(cur_src_d[OFF_W-1:0], rem_d);
`endif
        busy_d      = (state_d != IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_cnt_q   <= '0;
            cur_src_q   <= '0;
            cur_dst_q   <= '0;
            rem_q       <= '0;
            req_valid_q <= 1'b0;
            req_len_q   <= '0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_cnt_q   <= out_cnt_d;
            cur_src_q   <= cur_src_d;
            cur_dst_q   <= cur_dst_d;
            rem_q       <= rem_d;
            req_valid_q <= req_valid_d;
            req_len_q   <= req_len_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            if (store) begin
                fifo_src_q[wr_ptr_q] <= desc_src_i;
                fifo_dst_q[wr_ptr_q] <= desc_dst_i;
                fifo_len_q[wr_ptr_q] <= desc_len_i;
            end
        end
    end

    assign req_valid_o = req_valid_q;
    assign req_src_o   = cur_src_q;
    assign req_dst_o   = cur_dst_q;
    assign req_len_o   = req_len_q;
    assign irq_o       = irq_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign desc_cnt_o  = cnt_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_sy_dma_desc_queue.sv
// Self-checking bench for sy_dma_desc_queue: every expected burst comes from a plain
// arithmetic splitter model; completions are generated 3 cycles after each accepted burst.
module tb_sy_dma_desc_queue;
    localparam int ADDR_W    = 64;
    localparam int LEN_W     = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 256;
    localparam int MAX_OUT   = 4;
    localparam int BL_W      = $clog2(MAX_BURST) + 1;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int W         = 2 * ADDR_W + BL_W;
`ifdef SY_DMA_DESC_4K_SPLIT_EN
    localparam int UNALIGNED_N = 4;
`else
    localparam int UNALIGNED_N = 3;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              desc_valid_i = 1'b0;
    logic              desc_ready_o;
    logic [ADDR_W-1:0] desc_src_i = '0;
    logic [ADDR_W-1:0] desc_dst_i = '0;
    logic [LEN_W-1:0]  desc_len_i = '0;
    logic              req_valid_o;
    logic              req_ready_i = 1'b0;
    logic [ADDR_W-1:0] req_src_o;
    logic [ADDR_W-1:0] req_dst_o;
    logic [BL_W-1:0]   req_len_o;
    logic              cpl_i = 1'b0;
    logic              irq_o;
    logic              err_o;
    logic              busy_o;
    logic [CW-1:0]     desc_cnt_o;
    logic [1:0]        dbg_state_o;

    int n_chk = 0, n_err = 0;
    int cyc = 0;
    int hs_cnt = 0, irq_cnt = 0, err_cnt = 0, exp_irq = 0, last_irq_cyc = -1;
    int hs_cyc_q[$];
    int cpl_sched[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] sb_e;
    bit auto_cpl = 0, man_cpl = 0, rdy_rand = 0, rdy_man = 0;

    sy_dma_desc_queue #(
        .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
        .desc_src_i(desc_src_i), .desc_dst_i(desc_dst_i), .desc_len_i(desc_len_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_src_o(req_src_o), .req_dst_o(req_dst_o), .req_len_o(req_len_o),
        .cpl_i(cpl_i), .irq_o(irq_o), .err_o(err_o), .busy_o(busy_o),
        .desc_cnt_o(desc_cnt_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- engine model: ready and delayed completions ----------------
    always @(posedge clk_i) begin
        #2;
        while (cpl_sched.size() > 0 && cpl_sched[0] < cyc) cpl_sched.delete(0);
        cpl_i = man_cpl;
        if (cpl_sched.size() > 0 && cpl_sched[0] == cyc) begin
            cpl_i = 1'b1;
            cpl_sched.delete(0);
        end
        req_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_man;
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk_i) begin
        if (req_valid_o && req_ready_i) begin
            hs_cnt++;
            hs_cyc_q.push_back(cyc);
            n_chk++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected got src=%h dst=%h len=%0d want no burst",
                         req_src_o, req_dst_o, req_len_o);
            end else begin
                sb_e = exp_q[0];
                exp_q.delete(0);
                if ({req_src_o, req_dst_o, req_len_o} !== sb_e) begin
                    n_err++;
                    $display("FAIL sb_burst got src=%h dst=%h len=%0d want src=%h dst=%h len=%0d",
                             req_src_o, req_dst_o, req_len_o,
                             sb_e[W-1 -: ADDR_W], sb_e[W-ADDR_W-1 -: ADDR_W], sb_e[BL_W-1:0]);
                end
            end
            if (auto_cpl) cpl_sched.push_back(cyc + 3);
        end
        if (irq_o) begin
            irq_cnt++;
            last_irq_cyc = cyc;
        end
        if (err_o) err_cnt++;
    end

    // ---------------- reference model ----------------
    task automatic model_push(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
        logic [63:0] cs, cd, r, b, lim;
        cs = s;
        cd = d;
        r  = 64'(l);
        while (r != 0) begin
            b = 64'(MAX_BURST) - (cs % 64'(MAX_BURST));
`ifdef SY_DMA_DESC_4K_SPLIT_EN
            lim = 64'd4096 - (cd % 64'd4096);
            if (lim < b) b = lim;
`else
            lim = b;
`endif
            if (r < b) b = r;
            exp_q.push_back({cs, cd, b[BL_W-1:0]});
            cs = cs + b;
            cd = cd + b;
            r  = r - b;
        end
        if (l != 0) exp_irq++;
    endtask

    // ---------------- drivers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_desc(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l,
                             output int pc);
        int t;
        desc_valid_i = 1'b1;
        desc_src_i   = s;
        desc_dst_i   = d;
        desc_len_i   = l;
        t = 0;
        @(negedge clk_i);
        while (!desc_ready_o && t < 3000) begin
            @(negedge clk_i);
            t++;
        end
        pc = cyc;
        n_chk++;
        if (!desc_ready_o) begin
            n_err++;
            $display("FAIL push_accept got ready=0 after %0d cycles want ready=1", t);
        end else begin
            model_push(s, d, l);
        end
        @(posedge clk_i);
        #1;
        desc_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int t;
        t = 0;
        @(negedge clk_i);
        while ((irq_cnt != exp_irq || exp_q.size() != 0 || busy_o) && t < budget) begin
            @(negedge clk_i);
            t++;
        end
        n_chk++;
        if (irq_cnt != exp_irq || exp_q.size() != 0 || busy_o) begin
            n_err++;
            $display("FAIL wait_done got irq=%0d left=%0d busy=%0d want irq=%0d left=0 busy=0",
                     irq_cnt, exp_q.size(), busy_o, exp_irq);
        end
        @(posedge clk_i);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_i = 1'b0;
        tick(2);
        @(negedge clk_i);
        n_chk += 3;
        if ({req_valid_o, irq_o, err_o, busy_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags got v/irq/err/busy=%b want 0000", {req_valid_o, irq_o, err_o, busy_o});
        end
        if (desc_ready_o !== 1'b1 || desc_cnt_o !== '0) begin
            n_err++;
            $display("FAIL reset_fifo got ready=%b cnt=%0d want ready=1 cnt=0", desc_ready_o, desc_cnt_o);
        end
        if (req_src_o !== '0 || req_dst_o !== '0 || req_len_o !== '0) begin
            n_err++;
            $display("FAIL reset_req got %h/%h/%0d want 0/0/0", req_src_o, req_dst_o, req_len_o);
        end
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        tick(1);
    endtask

    task automatic test_aligned_split();
        int pc, base_irq, first, last;
        rdy_man = 1;
        auto_cpl = 1;
        hs_cyc_q.delete();
        base_irq = irq_cnt;
        push_desc(64'h8000_0000, 64'h8010_0000, 600, pc);
        wait_done(200);
        first = (hs_cyc_q.size() > 0) ? hs_cyc_q[0] : -1;
        last  = (hs_cyc_q.size() > 2) ? hs_cyc_q[2] : -1;
        n_chk += 5;
        if (hs_cyc_q.size() != 3) begin
            n_err++;
            $display("FAIL aligned_count got %0d bursts want 3", hs_cyc_q.size());
        end
        if (first != pc + 2) begin
            n_err++;
            $display("FAIL aligned_latency got first req cycle %0d want %0d", first, pc + 2);
        end
        if (last != pc + 4) begin
            n_err++;
            $display("FAIL back_to_back got third req cycle %0d want %0d", last, pc + 4);
        end
        if (last_irq_cyc != pc + 8) begin
            n_err++;
            $display("FAIL irq_timing got irq cycle %0d want %0d", last_irq_cyc, pc + 8);
        end
        if (irq_cnt - base_irq != 1) begin
            n_err++;
            $display("FAIL aligned_irq got %0d irq pulses want 1", irq_cnt - base_irq);
        end
    endtask

    task automatic test_unaligned();
        int pc;
        rdy_man = 1;
        auto_cpl = 1;
        hs_cyc_q.delete();
        push_desc(64'h8000_00F0, 64'h8010_0FF8, 300, pc);
        wait_done(200);
        n_chk++;
        if (hs_cyc_q.size() != UNALIGNED_N) begin
            n_err++;
            $display("FAIL unaligned_count got %0d bursts want %0d", hs_cyc_q.size(), UNALIGNED_N);
        end
    endtask

    task automatic test_errors();
        int pc, base_err;
        base_err = err_cnt;
        push_desc(64'h1234, 64'h5678, 0, pc);
        @(negedge clk_i);
        n_chk += 2;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_zero_len got err=%b want 1", err_o);
        end
        if (desc_cnt_o !== '0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL zero_len_store got cnt=%0d busy=%b want 0/0", desc_cnt_o, busy_o);
        end
        @(posedge clk_i);
        #1;
        man_cpl = 1;
        tick(1);
        man_cpl = 0;
        @(negedge clk_i);
        n_chk += 2;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL err_spurious_cpl got err=%b want 1", err_o);
        end
        if (req_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_cpl got valid=%b busy=%b want 0/0", req_valid_o, busy_o);
        end
        @(negedge clk_i);
        n_chk++;
        if (err_cnt - base_err != 2) begin
            n_err++;
            $display("FAIL err_pulses got %0d want 2", err_cnt - base_err);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_outstanding();
        int pc, base_hs, base_err;
        auto_cpl = 0;
        rdy_man = 1;
        base_hs = hs_cnt;
        base_err = err_cnt;
        push_desc(64'h1000_0000, 64'h2000_0000, 2048, pc);
        tick(12);
        @(negedge clk_i);
        n_chk++;
        if (hs_cnt - base_hs != MAX_OUT || req_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL out_limit got hs=%0d valid=%b want hs=%0d valid=0", hs_cnt - base_hs, req_valid_o, MAX_OUT);
        end
        @(posedge clk_i);
        #1;
        man_cpl = 1;
        tick(1);
        man_cpl = 0;
        tick(6);
        @(negedge clk_i);
        n_chk++;
        if (hs_cnt - base_hs != MAX_OUT + 1 || req_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL out_one_more got hs=%0d valid=%b want hs=%0d valid=0", hs_cnt - base_hs, req_valid_o, MAX_OUT + 1);
        end
        @(posedge clk_i);
        #1;
        rdy_man = 0;
        man_cpl = 1;
        tick(1);
        man_cpl = 0;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            sb_e = exp_q[0];
            n_chk++;
            if ({req_valid_o, req_src_o, req_dst_o, req_len_o} !== {1'b1, sb_e}) begin
                n_err++;
                $display("FAIL hold_stable got v=%b %h/%h/%0d want v=1 %h/%h/%0d", req_valid_o,
                         req_src_o, req_dst_o, req_len_o,
                         sb_e[W-1 -: ADDR_W], sb_e[W-ADDR_W-1 -: ADDR_W], sb_e[BL_W-1:0]);
            end
        end
        @(posedge clk_i);
        #1;
        for (int i = 0; i < 3; i++) begin
            man_cpl = 1;
            tick(1);
            man_cpl = 0;
            tick(1);
        end
        auto_cpl = 1;
        rdy_man = 1;
        wait_done(300);
        n_chk++;
        if (hs_cnt - base_hs != 8 || err_cnt != base_err) begin
            n_err++;
            $display("FAIL out_total got hs=%0d errs=%0d want hs=8 errs=0", hs_cnt - base_hs, err_cnt - base_err);
        end
    endtask

    task automatic test_fifo_full();
        int pc, base_irq;
        auto_cpl = 1;
        rdy_rand = 0;
        rdy_man = 0;
        base_irq = irq_cnt;
        push_desc({32'h0000_0003, $urandom()}, {32'h0000_0007, $urandom()}, 1500, pc);
        for (int i = 0; i < 4; i++)
            push_desc({32'h0000_0004, $urandom()}, {32'h0000_0005, $urandom()}, 32'($urandom_range(1, 900)), pc);
        @(negedge clk_i);
        n_chk += 2;
        if (desc_cnt_o !== CW'(DEPTH) || desc_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL fifo_full got cnt=%0d ready=%b want cnt=%0d ready=0", desc_cnt_o, desc_ready_o, DEPTH);
        end
        if (busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL busy_full got busy=%b want 1", busy_o);
        end
        @(posedge clk_i);
        #1;
        rdy_rand = 1;
        push_desc({32'h0000_0006, $urandom()}, {32'h0000_0002, $urandom()}, 32'($urandom_range(1, 900)), pc);
        wait_done(5000);
        n_chk++;
        if (irq_cnt - base_irq != 6) begin
            n_err++;
            $display("FAIL fifo_irqs got %0d irq pulses want 6", irq_cnt - base_irq);
        end
        rdy_rand = 0;
    endtask

    task automatic test_random();
        int pc, base_irq;
        logic [63:0] s, d;
        auto_cpl = 1;
        rdy_rand = 1;
        base_irq = irq_cnt;
        for (int i = 0; i < 8; i++) begin
            s = {$urandom(), $urandom()};
            d = {$urandom(), $urandom()};
            if (i == 0) s = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 300));
            push_desc(s, d, 32'($urandom_range(1, 1200)), pc);
        end
        wait_done(8000);
        n_chk++;
        if (irq_cnt - base_irq != 8) begin
            n_err++;
            $display("FAIL random_irqs got %0d irq pulses want 8", irq_cnt - base_irq);
        end
        rdy_rand = 0;
    endtask

    task automatic test_reset_mid();
        int pc, base_irq, base_hs;
        auto_cpl = 0;
        rdy_man = 1;
        push_desc(64'h4000_0000, 64'h5000_0000, 4000, pc);
        push_desc(64'h4100_0000, 64'h5100_0000, 100, pc);
        push_desc(64'h4200_0000, 64'h5200_0000, 200, pc);
        tick(8);
        cpl_sched.delete();
        rst_i = 1'b0;
        tick(1);
        rst_i = 1'b1;
        exp_q.delete();
        exp_irq -= 3;
        base_irq = irq_cnt;
        base_hs = hs_cnt;
        @(negedge clk_i);
        n_chk += 2;
        if ({req_valid_o, irq_o, err_o, busy_o, desc_cnt_o} !== '0 || desc_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_state got v/irq/err/busy=%b cnt=%0d ready=%b want 0000/0/1",
                     {req_valid_o, irq_o, err_o, busy_o}, desc_cnt_o, desc_ready_o);
        end
        if (req_src_o !== '0 || req_len_o !== '0) begin
            n_err++;
            $display("FAIL midreset_req got src=%h len=%0d want 0/0", req_src_o, req_len_o);
        end
        @(posedge clk_i);
        #1;
        man_cpl = 1;
        tick(1);
        man_cpl = 0;
        @(negedge clk_i);
        n_chk++;
        if (err_o !== 1'b1) begin
            n_err++;
            $display("FAIL cpl_after_reset got err=%b want 1", err_o);
        end
        tick(20);
        n_chk++;
        if (irq_cnt != base_irq || hs_cnt != base_hs) begin
            n_err++;
            $display("FAIL midreset_quiet got irq=%0d hs=%0d want 0/0", irq_cnt - base_irq, hs_cnt - base_hs);
        end
    endtask

    initial begin
        test_reset();
        test_aligned_split();
        test_unaligned();
        test_errors();
        test_outstanding();
        test_fifo_full();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
